// File: rtl/fir_pcpi_sequencer.sv
// -----------------------------------------------------------------------------
// fir_pcpi_sequencer
//
// Autonomous PCPI master for the FIR accelerator. It replaces the CPU core on
// the accelerator's PCPI port. It runs in two phases:
//   1. Load phase: reads all N*K coefficients from an external coefficient
//      memory and issues one LOADH command per word.
//   2. Run phase: accepts packed control words from an input stream and issues
//      them as CALCULATE commands. Results go to a 2-entry output FIFO.
//
// Ports
//   clk, resetn          clock; asynchronous active-low reset
//   cfg_start            one-cycle start pulse (honoured only when idle)
//   cfg_skip_load        sampled with cfg_start; 1 = go straight to run phase
//   cfg_stop             one-cycle stop request
//   busy                 high whenever the sequencer is not idle
//   loaded               coefficients valid; cleared by an aborted load
//   err_timeout          sticky accelerator timeout flag; cleared by cfg_start
//   coef_rd_en/coef_addr coefficient read port; coef_rdata is returned 1 cycle later
//   s_valid/s_ready      control-word input stream, carrying s_rs1/s_rs2
//   m_valid/m_ready      filtered-sample output stream, carrying m_sample
//   pcpi_*               PCPI master port towards the accelerator
// -----------------------------------------------------------------------------
module fir_pcpi_sequencer #(
   parameter int N                 = 8,
   parameter int K                 = 256,
   parameter int WIDTH_COEFFICIENT = 32,
   parameter int TIMEOUT           = 15,
   parameter int AW                = $clog2(N*K)
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         cfg_start,
   input  logic                         cfg_skip_load,
   input  logic                         cfg_stop,
   output logic                         busy,
   output logic                         loaded,
   output logic                         err_timeout,
   output logic                         coef_rd_en,
   output logic [AW-1:0]                coef_addr,
   input  logic [WIDTH_COEFFICIENT-1:0] coef_rdata,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [31:0]                  s_rs1,
   input  logic [31:0]                  s_rs2,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [31:0]                  m_sample,
   output logic                         pcpi_valid,
   output logic [31:0]                  pcpi_insn,
   output logic [31:0]                  pcpi_rs1,
   output logic [31:0]                  pcpi_rs2,
   input  logic                         pcpi_wr,
   input  logic [31:0]                  pcpi_rd,
   input  logic                         pcpi_ready
);

   localparam logic [31:0] LOADH     = 32'h0000_3027;
   localparam logic [31:0] CALCULATE = 32'h0000_2027;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, LD_RD, LD_CAP, LD_ISSUE, LD_GAP, RUN_WAIT, RUN_ISSUE, RUN_GAP
   } state_t;

   state_t        state_reg, state_next;
   logic [3:0]    a_reg, a_next;
   logic [KW-1:0] k_reg, k_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic          rd_en_reg, rd_en_next;
   logic          valid_reg, valid_next;
   logic [31:0]   insn_reg, insn_next;
   logic [31:0]   rs1_reg, rs1_next;
   logic [31:0]   rs2_reg, rs2_next;
   logic          loaded_reg, loaded_next;
   logic          err_reg, err_next;
   logic          stop_reg, stop_next;
   logic [TW-1:0] tmo_reg, tmo_next;

   logic          push, pop, timeout_hit, load_phase, last_coef;

   // Output FIFO
   logic [31:0]   fifo_mem [2];
   logic          wr_ptr_reg, rd_ptr_reg;
   logic [1:0]    count_reg;

   assign load_phase  = (state_reg == LD_RD) || (state_reg == LD_CAP) ||
                        (state_reg == LD_ISSUE) || (state_reg == LD_GAP);
   assign last_coef   = (a_reg == 4'(N-1)) && (k_reg == KW'(K-1));
   // Fires on the cycle the stall counter would reach TIMEOUT.
   assign timeout_hit = valid_reg && !pcpi_ready && (tmo_reg == TW'(TIMEOUT-1));

   // s_ready also drops on a stop request so a word is never accepted on the
   // same cycle the sequencer leaves RUN_WAIT for IDLE.
   assign s_ready  = (state_reg == RUN_WAIT) && (count_reg != 2'd2) && !cfg_stop;
   assign m_valid  = (count_reg != 2'd0);
   assign m_sample = fifo_mem[rd_ptr_reg];
   assign pop      = m_valid && m_ready;

   assign busy        = (state_reg != IDLE);
   assign loaded      = loaded_reg;
   assign err_timeout = err_reg;
   assign coef_rd_en  = rd_en_reg;
   assign coef_addr   = addr_reg;
   assign pcpi_valid  = valid_reg;
   assign pcpi_insn   = insn_reg;
   assign pcpi_rs1    = rs1_reg;
   assign pcpi_rs2    = rs2_reg;

   // State and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         k_reg      <= '0;
         addr_reg   <= '0;
         rd_en_reg  <= 1'b0;
         valid_reg  <= 1'b0;
         insn_reg   <= '0;
         rs1_reg    <= '0;
         rs2_reg    <= '0;
         loaded_reg <= 1'b0;
         err_reg    <= 1'b0;
         stop_reg   <= 1'b0;
         tmo_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         k_reg      <= k_next;
         addr_reg   <= addr_next;
         rd_en_reg  <= rd_en_next;
         valid_reg  <= valid_next;
         insn_reg   <= insn_next;
         rs1_reg    <= rs1_next;
         rs2_reg    <= rs2_next;
         loaded_reg <= loaded_next;
         err_reg    <= err_next;
         stop_reg   <= stop_next;
         tmo_reg    <= tmo_next;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      k_next      = k_reg;
      addr_next   = addr_reg;
      rd_en_next  = 1'b0;
      valid_next  = valid_reg;
      insn_next   = insn_reg;
      rs1_next    = rs1_reg;
      rs2_next    = rs2_reg;
      loaded_next = loaded_reg;
      err_next    = err_reg;
      stop_next   = stop_reg;
      tmo_next    = (valid_reg && !pcpi_ready) ? tmo_reg + TW'(1) : '0;
      push        = 1'b0;

      // A stop outside IDLE/RUN_WAIT waits for the current command to finish.
      if (cfg_stop && (state_reg != IDLE) && (state_reg != RUN_WAIT))
         stop_next = 1'b1;

      case (state_reg)
         IDLE: begin
            if (cfg_start) begin
               err_next  = 1'b0;
               stop_next = 1'b0;
               a_next    = '0;
               k_next    = '0;
               if (cfg_skip_load) begin
                  state_next = RUN_WAIT;
               end else begin
                  state_next = LD_RD;
                  rd_en_next = 1'b1;
                  addr_next  = '0;
               end
            end
         end
         LD_RD: state_next = LD_CAP;
         LD_CAP: begin
            rs1_next   = 32'(coef_rdata);
            rs2_next   = {28'b0, a_reg};
            valid_next = 1'b1;
            insn_next  = LOADH;
            state_next = LD_ISSUE;
         end
         LD_ISSUE: begin
            if (pcpi_ready) begin
               valid_next = 1'b0;
               insn_next  = '0;
               state_next = LD_GAP;
            end
         end
         LD_GAP: begin
            if (stop_reg || cfg_stop) begin
               // Aborted load: the accelerator holds a partial coefficient set.
               loaded_next = 1'b0;
               stop_next   = 1'b0;
               state_next  = IDLE;
            end else if (last_coef) begin
               loaded_next = 1'b1;
               a_next      = '0;
               k_next      = '0;
               state_next  = RUN_WAIT;
            end else begin
               // coef_addr tracks a*K+k, so it simply increments.
               if (k_reg == KW'(K-1)) begin
                  k_next = '0;
                  a_next = a_reg + 4'd1;
               end else begin
                  k_next = k_reg + KW'(1);
               end
               addr_next  = addr_reg + AW'(1);
               rd_en_next = 1'b1;
               state_next = LD_RD;
            end
         end
         RUN_WAIT: begin
            if (cfg_stop) begin
               state_next = IDLE;
            end else if (s_valid && s_ready) begin
               rs1_next   = s_rs1;
               rs2_next   = s_rs2;
               valid_next = 1'b1;
               insn_next  = CALCULATE;
               state_next = RUN_ISSUE;
            end
         end
         RUN_ISSUE: begin
            if (pcpi_ready) begin
               valid_next = 1'b0;
               insn_next  = '0;
               push       = pcpi_wr;
               state_next = RUN_GAP;
            end
         end
         RUN_GAP: begin
            if (stop_reg || cfg_stop) begin
               stop_next  = 1'b0;
               state_next = IDLE;
            end else begin
               state_next = RUN_WAIT;
            end
         end
         default: state_next = IDLE;
      endcase

      if (timeout_hit) begin
         err_next   = 1'b1;
         valid_next = 1'b0;
         insn_next  = '0;
         stop_next  = 1'b0;
         tmo_next   = '0;
         state_next = IDLE;
         if (load_phase)
            loaded_next = 1'b0;
      end
   end

   // Two-entry output FIFO. The s_ready free-slot rule prevents overflow,
   // because at most one CALCULATE is in flight at a time.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
         for (int i = 0; i < 2; i++)
            fifo_mem[i] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr_reg] <= pcpi_rd;
            wr_ptr_reg           <= ~wr_ptr_reg;
         end
         if (pop)
            rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_fir_pcpi_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_pcpi_sequencer
//
// Directed bench for fir_pcpi_sequencer with N=3, K=4 and TIMEOUT=15.
// The bench provides a coefficient ROM model (ROM[i] = i+100) and an
// accelerator model. The accelerator raises ready one cycle after valid and,
// for CALCULATE, returns pcpi_rd = rs1 - rs2. Expected PCPI commands and
// expected samples are queued and popped as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_fir_pcpi_sequencer;

   localparam int N  = 3;
   localparam int K  = 4;
   localparam int AW = 4;
   localparam logic [31:0] LOADH     = 32'h0000_3027;
   localparam logic [31:0] CALCULATE = 32'h0000_2027;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } cmd_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cfg_start = 1'b0, cfg_skip_load = 1'b0, cfg_stop = 1'b0;
   logic          busy, loaded, err_timeout, coef_rd_en;
   logic [AW-1:0] coef_addr;
   logic [31:0]   coef_rdata = '0;
   logic          s_valid = 1'b0, s_ready;
   logic [31:0]   s_rs1 = '0, s_rs2 = '0;
   logic          m_valid, m_ready = 1'b1;
   logic [31:0]   m_sample;
   logic          pcpi_valid;
   logic [31:0]   pcpi_insn, pcpi_rs1, pcpi_rs2;
   logic          pcpi_wr = 1'b0, pcpi_ready = 1'b0;
   logic [31:0]   pcpi_rd = '0;
   logic          acc_respond = 1'b1, acc_wr = 1'b1;

   int   n_checks = 0, n_fail = 0, cyc = 0, hs_cyc = 0, n_samples = 0;
   bit   accepted = 1'b0;
   cmd_t        exp_cmd_q[$];
   logic [31:0] exp_sample_q[$];

   fir_pcpi_sequencer #(.N(N), .K(K), .WIDTH_COEFFICIENT(32), .TIMEOUT(15)) dut (
      .clk(clk), .resetn(resetn),
      .cfg_start(cfg_start), .cfg_skip_load(cfg_skip_load), .cfg_stop(cfg_stop),
      .busy(busy), .loaded(loaded), .err_timeout(err_timeout),
      .coef_rd_en(coef_rd_en), .coef_addr(coef_addr), .coef_rdata(coef_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_rs1(s_rs1), .s_rs2(s_rs2),
      .m_valid(m_valid), .m_ready(m_ready), .m_sample(m_sample),
      .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
      .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_ready(pcpi_ready)
   );

   always #5 clk = ~clk;

   // Coefficient ROM and accelerator models
   always @(posedge clk) begin
      if (coef_rd_en)
         coef_rdata <= 32'd100 + 32'(coef_addr);
      pcpi_ready <= acc_respond && pcpi_valid && !pcpi_ready;
      pcpi_wr    <= acc_respond && acc_wr && pcpi_valid && !pcpi_ready &&
                    (pcpi_insn == CALCULATE);
      pcpi_rd    <= pcpi_rs1 - pcpi_rs2;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample at the falling edge, then step past the rising edge.
   task automatic step();
      cmd_t        c;
      logic [31:0] s;
      @(negedge clk);
      cyc++;
      if (!pcpi_valid)
         chk("insn_idle", pcpi_insn, 32'd0);
      if (pcpi_valid && pcpi_ready) begin
         if (exp_cmd_q.size() == 0) begin
            chk("cmd_unexpected", 32'(exp_cmd_q.size()), 32'd1);
         end else begin
            c = exp_cmd_q.pop_front();
            chk("cmd_insn", pcpi_insn, c.insn);
            chk("cmd_rs1", pcpi_rs1, c.rs1);
            chk("cmd_rs2", pcpi_rs2, c.rs2);
            $display("cmd insn=%h rs1=%0d rs2=%0d", pcpi_insn, pcpi_rs1, pcpi_rs2);
         end
      end
      if (m_valid && m_ready) begin
         n_samples++;
         if (exp_sample_q.size() == 0) begin
            chk("sample_unexpected", 32'(exp_sample_q.size()), 32'd1);
         end else begin
            s = exp_sample_q.pop_front();
            chk("m_sample", m_sample, s);
            $display("sample %0d", m_sample);
         end
      end
      if (s_valid && s_ready) begin
         accepted = 1'b1;
         hs_cyc   = cyc;
         if (acc_respond) begin
            exp_cmd_q.push_back({CALCULATE, s_rs1, s_rs2});
            if (acc_wr)
               exp_sample_q.push_back(s_rs1 - s_rs2);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic pulse_stop();
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
   endtask

   task automatic push_loads(input int count);
      for (int i = 0; i < count; i++)
         exp_cmd_q.push_back({LOADH, 32'(100 + i), 32'(i / K)});
   endtask

   // Full load from IDLE; the cycle count runs from the first LD_RD cycle.
   task automatic full_load();
      int n;
      push_loads(N * K);
      cfg_skip_load = 1'b0;
      pulse_start();
      chk("start_rd_en", 32'(coef_rd_en), 32'd1);
      chk("start_addr", 32'(coef_addr), 32'd0);
      n = 0;
      while (!loaded && n < 400) begin
         step();
         n++;
      end
      chk("load_cycles", 32'(n), 32'(5 * N * K));
      chk("loaded", 32'(loaded), 32'd1);
      chk("load_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
   endtask

   // Offers one control word that yields sample v and waits for acceptance.
   task automatic send_word(input int v);
      int x;
      x        = int'($urandom_range(0, 1000));
      s_rs1    = 32'(v + x);
      s_rs2    = 32'(x);
      s_valid  = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 50 && !accepted; i++)
         step();
      chk("s_accept", 32'(accepted), 32'd1);
      s_valid = 1'b0;
   endtask

   initial begin
      int h1, n0, n;

      // Reset values
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_loaded", 32'(loaded), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_rd_en", 32'(coef_rd_en), 32'd0);
      chk("rst_addr", 32'(coef_addr), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_sample", m_sample, 32'd0);
      chk("rst_valid", 32'(pcpi_valid), 32'd0);
      chk("rst_insn", pcpi_insn, 32'd0);
      chk("rst_rs1", pcpi_rs1, 32'd0);
      chk("rst_rs2", pcpi_rs2, 32'd0);
      resetn = 1'b1;
      step();

      // Full coefficient load
      full_load();
      chk("run_s_ready", 32'(s_ready), 32'd1);

      // Stop in RUN_WAIT takes effect on the next cycle
      pulse_stop();
      chk("stop_wait_busy", 32'(busy), 32'd0);
      chk("stop_wait_loaded", 32'(loaded), 32'd1);

      // Skip-load start and three streamed words
      cfg_skip_load = 1'b1;
      pulse_start();
      chk("skip_busy", 32'(busy), 32'd1);
      chk("skip_rd_en", 32'(coef_rd_en), 32'd0);
      n0 = n_samples;
      send_word(7);
      h1 = hs_cyc;
      send_word(8);
      chk("calc_spacing", 32'(hs_cyc - h1), 32'd4);
      send_word(9);
      repeat (8) step();
      chk("stream_samples", 32'(n_samples - n0), 32'd3);
      chk("stream_left", 32'(exp_sample_q.size()), 32'd0);

      // A response without pcpi_wr produces no sample
      acc_wr = 1'b0;
      n0 = n_samples;
      send_word(55);
      repeat (6) step();
      chk("nowr_samples", 32'(n_samples - n0), 32'd0);
      chk("nowr_m_valid", 32'(m_valid), 32'd0);
      chk("nowr_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
      acc_wr = 1'b1;

      // Backpressure: two samples buffered, third word held off until a pop
      m_ready = 1'b0;
      send_word(21);
      send_word(22);
      s_rs1 = 32'd123; s_rs2 = 32'd100;
      s_valid  = 1'b1;
      accepted = 1'b0;
      repeat (10) step();
      chk("bp_not_accepted", 32'(accepted), 32'd0);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      n0 = n_samples;
      m_ready = 1'b1;
      for (int i = 0; i < 20 && !accepted; i++)
         step();
      chk("bp_accept", 32'(accepted), 32'd1);
      chk("bp_pop_first", 32'(n_samples - n0 >= 1), 32'd1);
      s_valid = 1'b0;
      repeat (8) step();
      chk("bp_left", 32'(exp_sample_q.size()), 32'd0);

      // Stop during RUN_ISSUE: sample still delivered, idle after RUN_GAP
      send_word(44);
      pulse_stop();
      step();
      chk("stop_issue_gap_busy", 32'(busy), 32'd1);
      step();
      chk("stop_issue_idle", 32'(busy), 32'd0);
      repeat (3) step();
      chk("stop_issue_sample", 32'(exp_sample_q.size()), 32'd0);

      // Timeout during load, with loaded still set from the first load
      acc_respond   = 1'b0;
      cfg_skip_load = 1'b0;
      pulse_start();
      for (int i = 0; i < 10 && !pcpi_valid; i++)
         step();
      n = 0;
      while (pcpi_valid && n < 100) begin
         step();
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'd15);
      chk("tmo_err", 32'(err_timeout), 32'd1);
      chk("tmo_valid", 32'(pcpi_valid), 32'd0);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_loaded", 32'(loaded), 32'd0);
      acc_respond = 1'b1;

      // cfg_start clears the timeout flag
      cfg_skip_load = 1'b1;
      pulse_start();
      chk("start_clears_err", 32'(err_timeout), 32'd0);
      pulse_stop();

      // Reload, then abort a load with cfg_stop
      full_load();
      pulse_stop();
      push_loads(1);
      cfg_skip_load = 1'b0;
      pulse_start();
      pulse_stop();
      for (int i = 0; i < 20 && busy; i++)
         step();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_loaded", 32'(loaded), 32'd0);
      chk("abort_cmds_left", 32'(exp_cmd_q.size()), 32'd0);

      // Asynchronous reset during LD_ISSUE
      pulse_start();
      for (int i = 0; i < 10 && !pcpi_valid; i++)
         step();
      chk("pre_reset_valid", 32'(pcpi_valid), 32'd1);
      resetn = 1'b0;
      #1;
      chk("areset_valid", 32'(pcpi_valid), 32'd0);
      chk("areset_insn", pcpi_insn, 32'd0);
      chk("areset_rs1", pcpi_rs1, 32'd0);
      chk("areset_busy", 32'(busy), 32'd0);
      chk("areset_rd_en", 32'(coef_rd_en), 32'd0);
      repeat (2) step();
      resetn = 1'b1;
      step();
      full_load();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fir_pcpi_sequencer.md
# fir_pcpi_sequencer

Autonomous PCPI master that drives the FIR accelerator (`FIR_accelerator`) without CPU involvement. It loads all N×K coefficients from an external coefficient ROM/RAM with LOADH commands, then streams packed control-sequence words from an input stream as CALCULATE commands. It returns each filtered sample on a valid/ready output stream. It sits between the control-sequence source and the accelerator's PCPI port, in place of the CPU core.

## Interface
- N, 8, analog states; legal values 3..8
- K, 256, FIR taps per analog state
- WIDTH_COEFFICIENT, 32, coefficient word width
- TIMEOUT, 15, maximum cycles pcpi_valid may stay high without pcpi_ready
- AW, $clog2(N*K), coefficient address width

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- cfg_start  in  1  one-cycle start pulse
- cfg_skip_load  in  1  sampled with cfg_start; 1 = skip the coefficient load phase
- cfg_stop  in  1  one-cycle stop request
- busy  out  1  high whenever state ≠ IDLE
- loaded  out  1  coefficients valid; sticky until a load is aborted or reset
- err_timeout  out  1  sticky; cleared by cfg_start
- coef_rd_en  out  1  coefficient read strobe
- coef_addr  out  AW  coefficient address
- coef_rdata  in  WIDTH_COEFFICIENT  read data, valid exactly 1 cycle after coef_rd_en
- s_valid, s_ready  in/out  1  control-word stream handshake
- s_rs1, s_rs2  in  32  packed control bits, forwarded unchanged to the accelerator
- m_valid, m_ready  out/in  1  sample stream handshake
- m_sample  out  32  filtered sample
- pcpi_valid  out  1;  pcpi_insn  out  32;  pcpi_rs1, pcpi_rs2  out  32
- pcpi_wr  in  1;  pcpi_rd  in  32;  pcpi_ready  in  1

## Operation
- Command encodings, driven exactly:
  - LOADH = 32'h0000_3027
  - CALCULATE = 32'h0000_2027
  - pcpi_insn = 0 when not issuing
- FSM states: IDLE, LD_RD, LD_CAP, LD_ISSUE, LD_GAP, RUN_WAIT, RUN_ISSUE, RUN_GAP.
- IDLE: on cfg_start, clear err_timeout and go to LD_RD (cfg_skip_load=0) or RUN_WAIT (cfg_skip_load=1). cfg_start is ignored in every other state.
- Load phase: counters a (0..N-1) and k (0..K-1), both start at 0.
  - LD_RD: coef_rd_en=1, coef_addr=a*K+k.
  - LD_CAP: register coef_rdata into pcpi_rs1 and {28'b0,a[3:0]} into pcpi_rs2; set pcpi_valid.
  - LD_ISSUE: hold pcpi_valid and pcpi_insn=LOADH until pcpi_ready.
  - LD_GAP: pcpi_valid=0 for exactly 1 cycle, then advance k, wrapping to 0 and incrementing a. After (a=N-1, k=K-1), set loaded=1 and go to RUN_WAIT; otherwise go to LD_RD.
  - Net result: ROM word a*K+K-1 ends in tap 0 of analog state a.
- Run phase:
  - RUN_WAIT: s_ready=1 only here, and only when the output buffer has a free slot. On s_valid&&s_ready, latch s_rs1/s_rs2 into pcpi_rs1/rs2, assert pcpi_valid, and go to RUN_ISSUE.
  - RUN_ISSUE: hold pcpi_valid with insn=CALCULATE until pcpi_ready. On pcpi_ready&&pcpi_wr, push pcpi_rd into the output buffer. pcpi_ready without pcpi_wr pushes nothing.
  - RUN_GAP: 1 idle cycle, then RUN_WAIT.
- Output buffer: 2-entry FIFO. m_valid = not empty; m_sample = head entry. Pop on m_valid&&m_ready. A push and a pop in the same cycle are both honoured. The free-slot rule for s_ready guarantees no overflow.
- cfg_stop:
  - In RUN_WAIT: go to IDLE next cycle.
  - In RUN_ISSUE/RUN_GAP: latch the request; go to IDLE after RUN_GAP.
  - In a load state: latch the request; finish the current handshake, go to IDLE, clear loaded.
  - Output buffer contents are retained in all cases.
- Timeout: a counter runs while pcpi_valid=1 && !pcpi_ready. Reaching TIMEOUT sets err_timeout, drops pcpi_valid, clears loaded if in the load phase, and goes to IDLE.

## Timing
- Reset values (all outputs 0 except none): state=IDLE, busy=0, loaded=0, err_timeout=0, coef_rd_en=0, coef_addr=0, s_ready=0, m_valid=0, m_sample=0, pcpi_valid=0, pcpi_insn=0, pcpi_rs1=0, pcpi_rs2=0. Buffer empty, all counters 0.
- All outputs are registered except s_ready and m_valid/m_sample, which are decoded from state and FIFO registers.
- With the accelerator responding (ready 1 cycle after valid):
  - LOADH costs 5 cycles; full load costs 5·N·K cycles.
  - CALCULATE costs 4 cycles from the s handshake to the next possible s_ready; the sample is visible on m_valid 1 cycle after pcpi_ready.
- cfg_start to first coef_rd_en: 1 cycle.
- pcpi_valid is never high in two consecutive commands without a ≥1-cycle low gap.
- Asynchronous reset mid-operation aborts immediately to the reset values; no partial command completes.

## Test plan
- Load, N=3, K=4, ROM[i]=i+100, accelerator model responds → 12 LOADH commands; rs2 sequence 0,0,0,0,1,…,2; rs1 = 100..111; loaded=1 after 60 cycles.
- cfg_skip_load=1, three s words, model returns pcpi_rd=7,8,9 with wr=1 → m_sample 7,8,9 in order; each CALCULATE carries the matching s_rs1/s_rs2.
- m_ready=0 while 3 words are offered → 2 samples buffered; s_ready stays 0 for the 3rd until one pop.
- Model never asserts pcpi_ready → after 15 cycles err_timeout=1, pcpi_valid=0, state IDLE, loaded=0.
- cfg_stop during RUN_ISSUE → the current sample is still delivered; next cycle after RUN_GAP busy=0. cfg_stop during load → loaded=0.
- resetn low during LD_ISSUE → all outputs at reset values within the same cycle; cfg_start afterwards restarts from address 0.
